// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   - arb_state_e : read data-phase tracking (IDLE / CPU_RD / DEV_RD)
//   - STARVE_W    : width of the device starvation counter
//   - DEF_AW/DW   : default address / data widths
//   - sat_inc16   : saturating 16-bit increment used by the access statistics
//                   (only referenced when DMEM_ARB_STATS_EN is defined)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DEF_AW   = 32;
    localparam int DEF_DW   = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DEV_RD = 2'd2
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the three sides of the arbiter: CPU load/store port, DMA device
//   port and the single-port synchronous data memory.
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (CPU, DMA engine, memory)
//
//   Handshakes:
//     CPU : an access is attempted while cpu_req=1; it completes in the first
//           cycle with cpu_stall=0 (for a load that is the data cycle, where
//           cpu_rdata is valid). cpu_we/addr/wdata stay stable until then.
//     DEV : dev_req is a valid that must be held with stable we/addr/wdata
//           until dev_gnt (ready) is seen; the issue happens in the cycle both
//           are high. Read data follows one cycle later with dev_rvalid=1.
//     MEM : mem_en=1 issues one access per cycle; read data appears on
//           mem_rdata the following cycle.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dev_req;
    logic          dev_we;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_wdata;
    logic          dev_gnt;
    logic [DW-1:0] dev_rdata;
    logic          dev_rvalid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dev_req, dev_we, dev_addr, dev_wdata,
        output dev_gnt, dev_rdata, dev_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dev_req, dev_we, dev_addr, dev_wdata,
        input  dev_gnt, dev_rdata, dev_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
//   Saturating up-counter with synchronous clear. Counts cycles in which the
//   device is requesting but not granted; at_max tells the arbiter to hand the
//   next slot to the device.
//   Ports:
//     clk, reset (sync, active-low)
//     clr    - clear to zero (has priority over inc)
//     inc    - increment, saturating at MAX
//     cnt    - current count
//     at_max - cnt == MAX
// -----------------------------------------------------------------------------
module starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_max
);

    localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port synchronous data memory between the MIPS core's
//   load/store port and the UART/IrDA DMA engine. One issue per cycle,
//   pipelined with the read data phase of the previous issue. The CPU normally
//   wins; after STARVE_MAX consecutive denied device cycles the device wins.
//
//   Ports:
//     clk        - rising-edge clock
//     reset      - synchronous, active-low
//     bus        - dmem_arbiter_if.slave (CPU, device and memory sides)
//     state_dbg  - current data-phase state
//     starve_dbg - current device starvation count
//   Optional (macro DMEM_ARB_STATS_EN):
//     cpu_acc_cnt, dev_acc_cnt - saturating 16-bit granted-issue counters
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_arbiter_if.slave       bus,
    output arb_state_e          state_dbg,
    output logic [STARVE_W-1:0] starve_dbg
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]         cpu_acc_cnt,
    output logic [15:0]         dev_acc_cnt
`endif
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic cpu_rd_phase;
    logic dev_rd_phase;
    logic cpu_eligible;
    logic cpu_issue;
    logic dev_issue;
    logic starve_at_max;
    logic starve_clr;
    logic starve_inc;

    logic          mem_en;
    logic          mem_we;
    logic          cpu_stall;

    // Issue selection, next state and memory port. Issues are gated by reset
    // so that nothing reaches the memory or the handshakes while reset is held.
    always_comb begin
        cpu_rd_phase = (state_q == CPU_RD);
        dev_rd_phase = (state_q == DEV_RD);

        // The CPU's own data cycle is not a new request: it stays on the bus
        // while cpu_req is still high, but the port is left free for the device.
        cpu_eligible = reset && bus.cpu_req && !cpu_rd_phase;
        dev_issue    = reset && bus.dev_req && (starve_at_max || !cpu_eligible);
        cpu_issue    = cpu_eligible && !dev_issue;

        state_d = IDLE;
        if (cpu_issue && !bus.cpu_we) begin
            state_d = CPU_RD;
        end else if (dev_issue && !bus.dev_we) begin
            state_d = DEV_RD;
        end

        mem_en  = 1'b0;
        mem_we  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (cpu_issue) begin
            mem_en  = 1'b1;
            mem_we  = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
        end else if (dev_issue) begin
            mem_en  = 1'b1;
            mem_we  = bus.dev_we;
            addr_d  = bus.dev_addr;
            wdata_d = bus.dev_wdata;
        end

        // Stall on any CPU request outside its data cycle, except a store that
        // completes in this very cycle.
        cpu_stall = cpu_eligible && !(cpu_issue && bus.cpu_we);

        starve_clr = dev_issue || !bus.dev_req;
        starve_inc = bus.dev_req && !dev_issue;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .clr    (starve_clr),
        .inc    (starve_inc),
        .cnt    (starve_dbg),
        .at_max (starve_at_max)
    );

    // Idle cycles present the last issued address/data to keep the memory
    // inputs quiet.
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = addr_d;
    assign bus.mem_wdata  = wdata_d;

    assign bus.cpu_stall  = cpu_stall;
    assign bus.cpu_rdata  = cpu_rd_phase ? bus.mem_rdata : '0;
    assign bus.dev_gnt    = dev_issue;
    assign bus.dev_rvalid = dev_rd_phase;
    assign bus.dev_rdata  = dev_rd_phase ? bus.mem_rdata : '0;

    assign state_dbg      = state_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_cnt_q, cpu_cnt_d;
    logic [15:0] dev_cnt_q, dev_cnt_d;

    always_comb begin
        cpu_cnt_d = cpu_issue ? sat_inc16(cpu_cnt_q) : cpu_cnt_q;
        dev_cnt_d = dev_issue ? sat_inc16(dev_cnt_q) : dev_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_cnt_q <= '0;
            dev_cnt_q <= '0;
        end else begin
            cpu_cnt_q <= cpu_cnt_d;
            dev_cnt_q <= dev_cnt_d;
        end
    end

    assign cpu_acc_cnt = cpu_cnt_q;
    assign dev_acc_cnt = dev_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small synchronous memory model.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic                clk;
    logic                reset;
    arb_state_e          state_dbg;
    logic [STARVE_W-1:0] starve_dbg;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]         cpu_acc_cnt;
    logic [15:0]         dev_acc_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int en_pulses = 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .state_dbg  (state_dbg),
        .starve_dbg (starve_dbg)
`ifdef DMEM_ARB_STATS_EN
        ,
        .cpu_acc_cnt (cpu_acc_cnt),
        .dev_acc_cnt (dev_acc_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (!reset) begin
            mem[16] <= 32'hDEADBEEF;   // 0x040
            mem[32] <= 32'hCAFEF00D;   // 0x080
            mem[64] <= 32'h12345678;   // 0x100
        end
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    always @(posedge clk) if (bus.mem_en) en_pulses <= en_pulses + 1;

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic drive_dev(input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.dev_req   = req;
        bus.dev_we    = we;
        bus.dev_addr  = addr;
        bus.dev_wdata = wdata;
    endtask

    task automatic drive_idle();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dev(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        drive_dev(1'b1, 1'b0, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall: got %0h exp 0", bus.cpu_stall); end
        checks++; if (bus.dev_gnt !== 1'b0) begin errors++; $display("FAIL rst_dev_gnt: got %0h exp 0", bus.dev_gnt); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %0h exp 0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0h exp 0", bus.mem_we); end
        checks++; if (bus.dev_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dev_rvalid: got %0h exp 0", bus.dev_rvalid); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %0h exp 0", bus.cpu_rdata); end
        checks++; if (bus.dev_rdata !== 32'h0) begin errors++; $display("FAIL rst_dev_rdata: got %0h exp 0", bus.dev_rdata); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", state_dbg, IDLE); end
        checks++; if (starve_dbg !== 4'd0) begin errors++; $display("FAIL rst_starve: got %0d exp 0", starve_dbg); end

        // First cycle out of reset: a CPU store issues immediately.
        next_cycle();
        reset = 1'b1;
        drive_cpu(1'b1, 1'b1, 32'h200, 32'hA5A50001);
        drive_dev(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rel_mem_en: got %0h exp 1", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rel_mem_we: got %0h exp 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL rel_mem_addr: got %0h exp 200", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'hA5A50001) begin errors++; $display("FAIL rel_mem_wdata: got %0h exp a5a50001", bus.mem_wdata); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rel_cpu_stall: got %0h exp 0", bus.cpu_stall); end

        // Idle: strobes drop, address holds.
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %0h exp 0", bus.mem_en); end
        checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL idle_addr_hold: got %0h exp 200", bus.mem_addr); end
    endtask

    task automatic test_cpu_read();
        int pulses0;
        pulses0 = en_pulses;
        next_cycle();
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_c0_stall: got %0h exp 1", bus.cpu_stall); end
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_c0_strobe: got en=%0h we=%0h exp en=1 we=0", bus.mem_en, bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL rd_c0_addr: got %0h exp 40", bus.mem_addr); end

        next_cycle();
        @(negedge clk);
        checks++; if (state_dbg !== CPU_RD) begin errors++; $display("FAIL rd_c1_state: got %0d exp %0d", state_dbg, CPU_RD); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_c1_stall: got %0h exp 0", bus.cpu_stall); end
        checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c1_rdata: got %0h exp deadbeef", bus.cpu_rdata); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rd_c1_mem_en: got %0h exp 0", bus.mem_en); end

        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++; if (en_pulses - pulses0 !== 1) begin errors++; $display("FAIL rd_en_pulses: got %0d exp 1", en_pulses - pulses0); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rd_c2_state: got %0d exp %0d", state_dbg, IDLE); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive_cpu(1'b1, 1'b1, 32'h84, 32'h11112222);
        @(negedge clk);
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL b2b_wr_stall: got %0h exp 0", bus.cpu_stall); end
        next_cycle();
        drive_cpu(1'b1, 1'b0, 32'h84, 32'h0);
        @(negedge clk);
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL b2b_rd_stall: got %0h exp 1", bus.cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'h11112222) begin errors++; $display("FAIL b2b_rd_data: got stall=%0h data=%0h exp stall=0 data=11112222", bus.cpu_stall, bus.cpu_rdata); end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_starvation();
        logic        exp_gnt;
        logic [31:0] exp_addr;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive_cpu(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'(i));
            drive_dev(1'b1, 1'b1, 32'h3F0, 32'h0000D0D0);
            @(negedge clk);
            exp_gnt  = ((i % 5) == 4);
            exp_addr = exp_gnt ? 32'h3F0 : 32'h300 + 32'(4 * i);
            checks++; if (bus.dev_gnt !== exp_gnt) begin errors++; $display("FAIL starve_gnt[%0d]: got %0h exp %0h", i, bus.dev_gnt, exp_gnt); end
            checks++; if (bus.cpu_stall !== exp_gnt) begin errors++; $display("FAIL starve_stall[%0d]: got %0h exp %0h", i, bus.cpu_stall, exp_gnt); end
            checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL starve_addr[%0d]: got %0h exp %0h", i, bus.mem_addr, exp_addr); end
            checks++; if (starve_dbg !== 4'(i % 5)) begin errors++; $display("FAIL starve_cnt[%0d]: got %0d exp %0d", i, starve_dbg, i % 5); end
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++; if (starve_dbg !== 4'd0) begin errors++; $display("FAIL starve_clr: got %0d exp 0", starve_dbg); end
    endtask

    task automatic test_dev_during_cpu_rd();
        next_cycle();
        drive_cpu(1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        checks++; if (bus.cpu_stall !== 1'b1 || bus.dev_gnt !== 1'b0) begin errors++; $display("FAIL ovl_c0: got stall=%0h gnt=%0h exp stall=1 gnt=0", bus.cpu_stall, bus.dev_gnt); end

        next_cycle();
        drive_dev(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        checks++; if (bus.dev_gnt !== 1'b1) begin errors++; $display("FAIL ovl_c1_gnt: got %0h exp 1", bus.dev_gnt); end
        checks++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ovl_c1_cpu: got stall=%0h data=%0h exp stall=0 data=cafef00d", bus.cpu_stall, bus.cpu_rdata); end
        checks++; if (bus.mem_addr !== 32'h100 || bus.mem_en !== 1'b1) begin errors++; $display("FAIL ovl_c1_mem: got addr=%0h en=%0h exp addr=100 en=1", bus.mem_addr, bus.mem_en); end

        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.dev_rvalid !== 1'b1 || bus.dev_rdata !== 32'h12345678) begin errors++; $display("FAIL ovl_c2_dev: got rvalid=%0h data=%0h exp rvalid=1 data=12345678", bus.dev_rvalid, bus.dev_rdata); end
        checks++; if (state_dbg !== DEV_RD) begin errors++; $display("FAIL ovl_c2_state: got %0d exp %0d", state_dbg, DEV_RD); end

        next_cycle();
        @(negedge clk);
        checks++; if (bus.dev_rvalid !== 1'b0) begin errors++; $display("FAIL ovl_c3_rvalid: got %0h exp 0", bus.dev_rvalid); end
    endtask

    task automatic test_reset_during_dev_rd();
        next_cycle();
        drive_dev(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        checks++; if (bus.dev_gnt !== 1'b1) begin errors++; $display("FAIL rdr_gnt: got %0h exp 1", bus.dev_gnt); end
        // Reset is sampled on the edge that would start the data phase.
        reset = 1'b0;
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.dev_rvalid !== 1'b0) begin errors++; $display("FAIL rdr_rvalid: got %0h exp 0", bus.dev_rvalid); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rdr_state: got %0d exp %0d", state_dbg, IDLE); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.dev_rvalid !== 1'b0) begin errors++; $display("FAIL rdr_rvalid_after: got %0h exp 0", bus.dev_rvalid); end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        next_cycle();
        reset = 1'b0;
        drive_idle();
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_cpu(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'(i));
            next_cycle();
        end
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive_dev(1'b1, 1'b1, 32'h500 + 32'(4 * i), 32'(i));
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        checks++; if (cpu_acc_cnt !== 16'd10) begin errors++; $display("FAIL stats_cpu: got %0d exp 10", cpu_acc_cnt); end
        checks++; if (dev_acc_cnt !== 16'd3) begin errors++; $display("FAIL stats_dev: got %0d exp 3", dev_acc_cnt); end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_cpu_read();
        test_back_to_back();
        test_starvation();
        test_dev_during_cpu_rd();
        test_reset_during_dev_rd();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
